mem_port_arbiter: RTL and testbench

- Shares one single-ported backing data/instruction memory between the instruction-fetch requester (I) and the MEM-stage data requester (D) of the 16-bit pipelined CPU.
- Sequences each access as a req/ready transaction and latches the response.
- Drives a pipeline stall while any requester is waiting.
- Bounds I starvation and aborts hung memory accesses with a watchdog.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 16 +
 rtl/mem_port_arbiter_wdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and constants for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W           = 16;
  localparam int unsigned ADDR_W           = 16;
  localparam int unsigned WDOG_W           = 8;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned TIMEOUT_DEF      = 255;

  // Response returned to the winner when the watchdog aborts an access.
  localparam logic [DATA_W-1:0] ERR_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_D = 2'd1,
    ST_GNT_I = 2'd2
  } state_t;

  typedef enum logic {
    PORT_D = 1'b0,
    PORT_I = 1'b1
  } port_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One req/ack memory channel. Used for the data requester, the fetch
// requester and the backing memory (where ack is the memory's ready).
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// Grant-state watchdog: counts cycles spent waiting on memory and flags
// the cycle in which the access has used up its TIMEOUT budget.
module mem_wdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  logic [WDOG_W-1:0] r_cnt;

  // r_cnt holds the number of grant cycles already completed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_timeout) begin
      r_cnt <= r_cnt + WDOG_W'(1);
    end
  end

  // The TIMEOUT-th grant cycle is the last one allowed.
  assign o_timeout = i_en && (r_cnt == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and data (D)
// requesters, with bounded I starvation and a hung-access watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_run,
  mem_port_arbiter_if.slave         d_if,
  mem_port_arbiter_if.slave         i_if,
  mem_port_arbiter_if.master        m_if,
  output logic                      o_stall,
  output logic                      o_err
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SC_W-1:0]   r_starve_cnt;
  port_t             r_port;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_d_rdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic              r_d_ack;
  logic              r_i_ack;
  logic              r_err;

  logic              w_m_req;
  logic              w_in_gnt;
  logic              w_starved;
  logic              w_grant;
  logic              w_grant_i;
  logic              w_timeout;
  logic              w_done;
  logic [DATA_W-1:0] w_resp;
  logic              w_unused;

  assign w_in_gnt  = w_m_req;
  assign w_starved = (r_starve_cnt == SC_W'(STARVE_LIMIT));
  assign w_grant   = (r_state == ST_IDLE) && i_run && (d_if.req || i_if.req);
  assign w_grant_i = i_if.req && (!d_if.req || w_starved);
  // m_ready and the watchdog may coincide; the real response wins.
  assign w_done    = w_in_gnt && (m_if.ack || w_timeout);
  assign w_resp    = m_if.ack ? m_if.rdata : ERR_DATA;

  mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (!w_in_gnt),
    .i_en      (w_in_gnt),
    .o_timeout (w_timeout)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next-state: grant from IDLE, return to IDLE on completion or abort
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:            if (w_grant) w_state_nxt = w_grant_i ? ST_GNT_I : ST_GNT_D;
      ST_GNT_D, ST_GNT_I: if (w_done)  w_state_nxt = ST_IDLE;
      default:            w_state_nxt = ST_IDLE;
    endcase
  end

  // outputs: memory request is asserted in both grant states
  always_comb begin
    w_m_req = 1'b0;
    case (r_state)
      ST_GNT_D, ST_GNT_I: w_m_req = 1'b1;
      default:            w_m_req = 1'b0;
    endcase
  end

  // latch the winner's request so the memory side is immune to requester changes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_port  <= PORT_D;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_grant) begin
      r_port  <= w_grant_i ? PORT_I : PORT_D;
      r_addr  <= w_grant_i ? i_if.addr : d_if.addr;
      r_wdata <= w_grant_i ? '0 : d_if.wdata;
      r_we    <= !w_grant_i && d_if.we;
    end
  end

  // count D grants made over a waiting fetch; any I grant or idle fetch clears it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (!i_if.req || (w_grant && w_grant_i)) begin
      r_starve_cnt <= '0;
    end else if (w_grant && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + SC_W'(1);
    end
  end

  // capture response into the winner's rdata and pulse its ack for one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d_rdata <= '0;
      r_i_rdata <= '0;
      r_d_ack   <= 1'b0;
      r_i_ack   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_d_ack <= 1'b0;
      r_i_ack <= 1'b0;
      if (w_done) begin
        if (r_port == PORT_I) begin
          r_i_rdata <= w_resp;
          r_i_ack   <= 1'b1;
        end else begin
          r_d_rdata <= w_resp;
          r_d_ack   <= 1'b1;
        end
        if (!m_if.ack) r_err <= 1'b1;
      end
    end
  end

  assign m_if.req   = w_m_req;
  assign m_if.we    = r_we;
  assign m_if.addr  = r_addr;
  assign m_if.wdata = r_wdata;

  assign d_if.rdata = r_d_rdata;
  assign d_if.ack   = r_d_ack;
  assign i_if.rdata = r_i_rdata;
  assign i_if.ack   = r_i_ack;

  assign o_stall = (d_if.req & ~r_d_ack) | (i_if.req & ~r_i_ack);
  assign o_err   = r_err;

  // The fetch port never writes.
  assign w_unused = ^{i_if.we, i_if.wdata};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-programmable memory.
module tb_mem_port_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic run   = 1'b0;
  logic stall;
  logic err;

  mem_port_arbiter_if d_if ();
  mem_port_arbiter_if i_if ();
  mem_port_arbiter_if m_if ();

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_run   (run),
    .d_if    (d_if),
    .i_if    (i_if),
    .m_if    (m_if),
    .o_stall (stall),
    .o_err   (err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          mem_lat = 1;   // m_req cycles until ready; 0 = never
  int          mem_cyc = 0;
  logic [15:0] mem_data = 16'h0;
  logic [6:0]  exp_i_seq = 7'b0010000;
  int          w;
  int          n;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the memory model answers after mem_lat request cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_if.req === 1'b1) mem_cyc++;
    else                   mem_cyc = 0;
    m_if.ack   = (m_if.req === 1'b1) && (mem_lat != 0) && (mem_cyc >= mem_lat);
    m_if.rdata = mem_data;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: observed=expired expected=finish");
    $fatal(1);
  end

  initial begin
    d_if.req = 1'b0; d_if.we = 1'b0; d_if.addr = '0; d_if.wdata = '0;
    i_if.req = 1'b0; i_if.we = 1'b0; i_if.addr = '0; i_if.wdata = '0;
    m_if.ack = 1'b0; m_if.rdata = '0;
    run = 1'b1;
    rst_n = 1'b0;
    repeat (2) tick();

    chk1 ("rst_m_req",   m_if.req,   1'b0);
    chk1 ("rst_m_we",    m_if.we,    1'b0);
    chk16("rst_m_addr",  m_if.addr,  16'h0);
    chk1 ("rst_d_ack",   d_if.ack,   1'b0);
    chk1 ("rst_i_ack",   i_if.ack,   1'b0);
    chk16("rst_d_rdata", d_if.rdata, 16'h0);
    chk1 ("rst_err",     err,        1'b0);
    chk1 ("rst_stall",   stall,      1'b0);
    rst_n = 1'b1;
    tick();

    // D read, zero-wait memory
    d_if.req = 1'b1; d_if.we = 1'b0; d_if.addr = 16'h0040;
    mem_lat = 1; mem_data = 16'h1234;
    #1;
    chk1("t1_stall_c0", stall, 1'b1);
    chk1("t1_mreq_c0", m_if.req, 1'b0);
    tick();
    chk1 ("t1_mreq_c1",  m_if.req,  1'b1);
    chk16("t1_maddr_c1", m_if.addr, 16'h0040);
    chk1 ("t1_mwe_c1",   m_if.we,   1'b0);
    chk1 ("t1_stall_c1", stall,     1'b1);
    chk1 ("t1_dack_c1",  d_if.ack,  1'b0);
    tick();
    chk1 ("t1_dack_c2",   d_if.ack,   1'b1);
    chk16("t1_drdata_c2", d_if.rdata, 16'h1234);
    chk1 ("t1_stall_c2",  stall,      1'b0);
    chk1 ("t1_mreq_c2",   m_if.req,   1'b0);
    d_if.req = 1'b0;
    tick();
    chk1("t1_dack_c3", d_if.ack, 1'b0);

    // D and I held together: D x4, I, D x2 with 2-cycle memory
    d_if.req = 1'b1; i_if.req = 1'b1;
    d_if.addr = 16'h0200; i_if.addr = 16'h0300;
    mem_lat = 2;
    for (int k = 0; k < 7; k++) begin
      w = 0;
      while (m_if.req !== 1'b1 && w < 5) begin tick(); w++; end
      chk1 ("t2_mreq", m_if.req, 1'b1);
      chk16("t2_maddr", m_if.addr, exp_i_seq[k] ? 16'h0300 : 16'h0200);
      chk1 ("t2_dack_in_gnt", d_if.ack, 1'b0);
      chk1 ("t2_iack_in_gnt", i_if.ack, 1'b0);
      mem_data = 16'(16'hA000 + k);
      w = 0;
      while (d_if.ack !== 1'b1 && i_if.ack !== 1'b1 && w < 5) begin tick(); w++; end
      chk1("t2_ack_excl", d_if.ack & i_if.ack, 1'b0);
      chk1("t2_dack", d_if.ack, !exp_i_seq[k]);
      chk1("t2_iack", i_if.ack, exp_i_seq[k]);
      if (exp_i_seq[k]) begin
        chk16("t2_irdata", i_if.rdata, 16'(16'hA000 + k));
        i_if.req = 1'b0;
      end else begin
        chk16("t2_drdata", d_if.rdata, 16'(16'hA000 + k));
      end
      if (k == 6) d_if.req = 1'b0;
    end
    tick();
    chk1("t2_mreq_end", m_if.req, 1'b0);
    chk1("t2_dack_end", d_if.ack, 1'b0);

    // D write with wdata changed after the grant
    d_if.req = 1'b1; d_if.we = 1'b1; d_if.addr = 16'h0100; d_if.wdata = 16'hBEEF;
    mem_lat = 3; mem_data = 16'h7777;
    tick();
    chk1 ("t3_mreq_c1",  m_if.req,   1'b1);
    chk1 ("t3_mwe_c1",   m_if.we,    1'b1);
    chk16("t3_maddr_c1", m_if.addr,  16'h0100);
    chk16("t3_mwd_c1",   m_if.wdata, 16'hBEEF);
    d_if.wdata = 16'h0; d_if.addr = 16'h0; d_if.we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk1 ("t3_mreq", m_if.req,   1'b1);
      chk1 ("t3_mwe",  m_if.we,    1'b1);
      chk16("t3_mwd",  m_if.wdata, 16'hBEEF);
      chk1 ("t3_dack", d_if.ack,   1'b0);
    end
    tick();
    chk1 ("t3_dack_on",  d_if.ack,   1'b1);
    chk16("t3_drdata",   d_if.rdata, 16'h7777);
    d_if.req = 1'b0;
    tick();
    chk1("t3_dack_once", d_if.ack, 1'b0);

    // m_ready in the 255th grant cycle: ready beats the watchdog
    d_if.req = 1'b1; d_if.addr = 16'h0010;
    mem_lat = 255; mem_data = 16'h0BAD;
    tick();
    n = 0;
    while (m_if.req === 1'b1 && n < 300) begin n++; tick(); end
    chk16("t4a_gnt_cycles", 16'(n), 16'd255);
    chk1 ("t4a_dack",   d_if.ack,   1'b1);
    chk16("t4a_drdata", d_if.rdata, 16'h0BAD);
    chk1 ("t4a_err",    err,        1'b0);
    d_if.req = 1'b0;
    tick();

    // memory never ready: watchdog abort of a fetch
    i_if.req = 1'b1; i_if.addr = 16'h0500;
    mem_lat = 0;
    tick();
    chk1("t4_err_pre", err, 1'b0);
    n = 0;
    while (m_if.req === 1'b1 && n < 300) begin n++; tick(); end
    chk16("t4_gnt_cycles", 16'(n), 16'd255);
    chk1 ("t4_iack",   i_if.ack,   1'b1);
    chk16("t4_irdata", i_if.rdata, 16'hFFFF);
    chk1 ("t4_err",    err,        1'b1);
    i_if.req = 1'b0;
    repeat (3) tick();
    chk1("t4_err_sticky", err, 1'b1);
    chk1("t4_iack_off", i_if.ack, 1'b0);

    // reset during GNT_D
    d_if.req = 1'b1; d_if.addr = 16'h0020;
    mem_lat = 0;
    tick();
    chk1("t5_mreq_gnt", m_if.req, 1'b1);
    #2;
    rst_n = 1'b0;
    d_if.req = 1'b0;
    #1;
    chk1 ("t5_mreq",   m_if.req,   1'b0);
    chk16("t5_maddr",  m_if.addr,  16'h0);
    chk1 ("t5_dack",   d_if.ack,   1'b0);
    chk16("t5_drdata", d_if.rdata, 16'h0);
    chk16("t5_irdata", i_if.rdata, 16'h0);
    chk1 ("t5_err",    err,        1'b0);
    chk1 ("t5_stall",  stall,      1'b0);
    repeat (2) tick();
    chk1("t5_dack_held", d_if.ack, 1'b0);
    rst_n = 1'b1;
    i_if.req = 1'b1; i_if.addr = 16'h0600;
    mem_lat = 1; mem_data = 16'h5A5A;
    tick();
    chk1 ("t5_post_mreq",  m_if.req,  1'b1);
    chk16("t5_post_maddr", m_if.addr, 16'h0600);
    tick();
    chk1 ("t5_post_iack",   i_if.ack,   1'b1);
    chk16("t5_post_irdata", i_if.rdata, 16'h5A5A);
    chk1 ("t5_post_dack",   d_if.ack,   1'b0);
    i_if.req = 1'b0;
    tick();

    // run gating
    run = 1'b0;
    i_if.req = 1'b1; i_if.addr = 16'h0700;
    mem_lat = 2; mem_data = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("t6_blocked_mreq", m_if.req, 1'b0);
      chk1("t6_blocked_stall", stall, 1'b1);
    end
    run = 1'b1;
    tick();
    chk1 ("t6_mreq",  m_if.req,  1'b1);
    chk16("t6_maddr", m_if.addr, 16'h0700);
    run = 1'b0;
    tick();
    chk1("t6_mreq_runlow", m_if.req, 1'b1);
    tick();
    chk1 ("t6_iack",   i_if.ack,   1'b1);
    chk16("t6_irdata", i_if.rdata, 16'h1111);
    i_if.req = 1'b0;
    tick();
    chk1("t6_iack_off", i_if.ack, 1'b0);
    run = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
